// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial data, config and status bundle for seq_detector_param
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int PL_W = $clog2(MAX_LEN + 1);

    logic               Din;
    logic               Din_valid;
    logic               Cfg_load;
    logic [MAX_LEN-1:0] Cfg_pattern;
    logic [PL_W-1:0]    Cfg_len;
    logic               Cfg_overlap;
    logic               Count_clr;
    logic               Y;
    logic [CNT_W-1:0]   Match_count;
    logic               Cfg_err;
    logic               Armed;

    modport master (
        output Din, Din_valid, Cfg_load, Cfg_pattern, Cfg_len, Cfg_overlap, Count_clr,
        input  Y, Match_count, Cfg_err, Armed
    );

    modport slave (
        input  Din, Din_valid, Cfg_load, Cfg_pattern, Cfg_len, Cfg_overlap, Count_clr,
        output Y, Match_count, Cfg_err, Armed
    );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial pattern detector with overlap control and saturating match counter
module seq_detector_param #(
    parameter int               MAX_LEN     = 8,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1101),
    parameter int               DEF_LEN     = 4,
    parameter bit               DEF_OVERLAP = 1'b1
) (
    input logic                 Clk,
    input logic                 Rst,
    seq_detector_param_if.slave bus
);
    localparam int              PL_W     = $clog2(MAX_LEN + 1);
    localparam logic [PL_W-1:0] MAX_FILL = PL_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [PL_W-1:0]    len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [PL_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               y_q, y_d;

    logic [MAX_LEN-1:0] hist_new;
    logic [MAX_LEN-1:0] len_mask;
    logic [PL_W-1:0]    fill_n;
    logic               match;
    logic               cfg_ok;

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        y_d    = 1'b0;

        hist_new = {hist_q[MAX_LEN-2:0], bus.Din};
        fill_n   = (fill_q == MAX_FILL) ? MAX_FILL : fill_q + 1'b1;
        // Only the low len bits of history and pattern take part in the compare.
        len_mask = ~({MAX_LEN{1'b1}} << len_q);
        match    = (fill_n >= len_q) && (((hist_new ^ pat_q) & len_mask) == '0);
        cfg_ok   = (bus.Cfg_len != '0) && (bus.Cfg_len <= MAX_FILL);

        if (bus.Cfg_load) begin
            if (cfg_ok) begin
                pat_d  = bus.Cfg_pattern;
                len_d  = bus.Cfg_len;
                ovl_d  = bus.Cfg_overlap;
                hist_d = '0;
                fill_d = '0;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (bus.Din_valid) begin
            hist_d = hist_new;
            fill_d = (match && !ovl_q) ? '0 : fill_n;
            y_d    = match;
            if (match && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (bus.Count_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= PL_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            y_q    <= y_d;
        end
    end

    assign bus.Y           = y_q;
    assign bus.Match_count = cnt_q;
    assign bus.Cfg_err     = err_q;
    assign bus.Armed       = (fill_q >= len_q);
endmodule
